// File: rtl/act_pkg.sv
// -----------------------------------------------------------------------------
// act_pkg
//  Shared definitions for the act_stream activation unit.
//  Contents:
//   act_mode_t : run-time activation selector
//                ACT_RELU / ACT_LEAKY / ACT_CLIP / ACT_BYPASS
//   ACT_VAL_W  : default element width (signed two's complement)
// -----------------------------------------------------------------------------
package act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_t;

    localparam int ACT_VAL_W = 16;

endpackage

// File: rtl/act_lane.sv
// -----------------------------------------------------------------------------
// act_lane
//  Combinational activation of a single signed element.
//  Ports:
//   x        in  VAL_W  element, signed
//   mode     in  2      activation select (act_mode_t)
//   clip_max in  VAL_W  clipped-ReLU ceiling, signed
//   y        out VAL_W  activated element, signed
// -----------------------------------------------------------------------------
module act_lane
    import act_pkg::*;
#(
    parameter int VAL_W      = ACT_VAL_W,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [VAL_W-1:0] x,
    input  act_mode_t               mode,
    input  logic signed [VAL_W-1:0] clip_max,
    output logic signed [VAL_W-1:0] y
);

    function automatic logic signed [VAL_W-1:0] relu(input logic signed [VAL_W-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

    // Arithmetic shift rounds toward minus infinity, so -1 stays -1.
    function automatic logic signed [VAL_W-1:0] leaky(input logic signed [VAL_W-1:0] v);
        return (v < 0) ? (v >>> LEAK_SHIFT) : v;
    endfunction

    // A negative ceiling forces zero: every non-negative x would exceed it
    // and the negative ceiling itself must never escape.
    function automatic logic signed [VAL_W-1:0] clip(input logic signed [VAL_W-1:0] v,
                                                     input logic signed [VAL_W-1:0] c);
        if (v < 0 || c < 0)
            return '0;
        return (v > c) ? c : v;
    endfunction

    always_comb begin
        y = x;
        case (mode)
            ACT_RELU:   y = relu(x);
            ACT_LEAKY:  y = leaky(x);
            ACT_CLIP:   y = clip(x, clip_max);
            ACT_BYPASS: y = x;
            default:    y = x;
        endcase
    end

endmodule

// File: rtl/act_stream.sv
// -----------------------------------------------------------------------------
// act_stream
//  Streaming two-stage activation unit for conv feature maps. LANES signed
//  elements per beat over valid/ready; activation selected per map; final beat
//  of each FM_W x FM_H map tagged with out_last.
//  Optional feature: define ACT_STREAM_STATS_EN to add negative-element
//  statistics (neg_count, stats_valid).
//  Ports:
//   clk, rst       clock, synchronous active-high reset
//   mode           activation select, sampled on first beat of a map
//   clip_max       clipped-ReLU ceiling, sampled with mode
//   in_valid/in_ready/in_data    input beat handshake (lane 0 at MSBs)
//   out_valid/out_ready/out_data output beat handshake (same packing)
//   out_last       final beat of a map
//   frame_done     pulse when the out_last beat is accepted
//   neg_count      (stats) negatives in the last completed map
//   stats_valid    (stats) pulse coincident with frame_done
// -----------------------------------------------------------------------------
module act_stream
    import act_pkg::*;
#(
    parameter int FM_W       = 5,
    parameter int FM_H       = 5,
    parameter int VAL_W      = ACT_VAL_W,
    parameter int LANES      = 5,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic signed [VAL_W-1:0]   clip_max,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*VAL_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*VAL_W-1:0]    out_data,
    output logic                      out_last,
    output logic                      frame_done
`ifdef ACT_STREAM_STATS_EN
    ,
    output logic [$clog2(FM_W*FM_H+1)-1:0] neg_count,
    output logic                           stats_valid
`endif
);

    localparam int NBEATS = (FM_W * FM_H) / LANES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    if ((FM_W * FM_H) % LANES != 0) begin : g_bad_lanes
        $error("act_stream: FM_W*FM_H must be a multiple of LANES");
    end

    logic                    advance;
    logic                    accept;
    logic                    out_fire;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    first_beat;
    logic                    last_beat;
    act_mode_t               mode_hold;
    logic signed [VAL_W-1:0] clip_hold;
    act_mode_t               mode_eff;
    logic signed [VAL_W-1:0] clip_eff;

    logic                    vld_p1;
    logic                    last_p1;
    logic [LANES*VAL_W-1:0]  data_p1;
    act_mode_t               mode_p1;
    logic signed [VAL_W-1:0] clip_p1;

    logic                    vld_p2;
    logic                    last_p2;
    logic [LANES*VAL_W-1:0]  data_p2;
    logic [LANES*VAL_W-1:0]  act_data;

    // Whole pipe moves as one; S1 never overwrites while S2 is stuck.
    assign advance    = !vld_p2 || out_ready;
    assign in_ready   = advance;
    assign accept     = in_valid && advance;
    assign out_fire   = vld_p2 && out_ready;

    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == LAST_CNT);

    // The first beat of a map uses the live inputs; later beats use the latch.
    assign mode_eff   = first_beat ? act_mode_t'(mode) : mode_hold;
    assign clip_eff   = first_beat ? clip_max : clip_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            mode_hold <= ACT_RELU;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            last_p2   <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (first_beat)
                    mode_hold <= act_mode_t'(mode);
            end
            if (advance) begin
                vld_p1  <= in_valid;
                last_p1 <= last_beat;
                vld_p2  <= vld_p1;
                last_p2 <= last_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && first_beat)
            clip_hold <= clip_max;
    end

    // ---- S1: sample beat with its effective mode/ceiling ----
    always_ff @(posedge clk) begin
        if (advance) begin
            data_p1 <= in_data;
            mode_p1 <= mode_eff;
            clip_p1 <= clip_eff;
        end
    end

    // ---- S2: activate every lane and register ----
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_lane #(
            .VAL_W      (VAL_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x        (data_p1[(LANES-1-i)*VAL_W +: VAL_W]),
            .mode     (mode_p1),
            .clip_max (clip_p1),
            .y        (act_data[(LANES-1-i)*VAL_W +: VAL_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            data_p2 <= '0;
        else if (advance)
            data_p2 <= act_data;
    end

    assign out_valid  = vld_p2;
    assign out_data   = data_p2;
    assign out_last   = last_p2;
    assign frame_done = out_fire && last_p2;

`ifdef ACT_STREAM_STATS_EN
    localparam int NEG_W = $clog2(FM_W*FM_H+1);

    logic [NEG_W-1:0] neg_beat_p1;
    logic [NEG_W-1:0] neg_p2;
    logic [NEG_W-1:0] neg_acc;
    logic [NEG_W-1:0] neg_hold;
    logic [NEG_W-1:0] neg_sum;

    // Negatives are counted on the raw input, independent of the mode.
    always_comb begin
        neg_beat_p1 = '0;
        for (int i = 0; i < LANES; i++)
            neg_beat_p1 = neg_beat_p1 + NEG_W'(data_p1[(i+1)*VAL_W-1]);
    end

    // Accumulated as beats leave so the total lines up with frame_done.
    assign neg_sum = neg_acc + neg_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_p2   <= '0;
            neg_acc  <= '0;
            neg_hold <= '0;
        end else begin
            if (advance)
                neg_p2 <= neg_beat_p1;
            if (out_fire) begin
                if (last_p2) begin
                    neg_acc  <= '0;
                    neg_hold <= neg_sum;
                end else begin
                    neg_acc  <= neg_sum;
                end
            end
        end
    end

    assign stats_valid = frame_done;
    assign neg_count   = stats_valid ? neg_sum : neg_hold;
`endif

endmodule
